// File: rtl/aes_pkg.sv
// Shared AES definitions: round constants, inverse S-box, GF(2^8) helpers,
// round-key slicing and the iterative decryptor FSM states.
package aes_pkg;

  localparam int NR   = 10;
  localparam int NK   = 4;
  localparam int RK_W = 128 * (NR + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } dec_state_e;

  // Row-major 16x16 table, entry 0 at the MSBs.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // 16:1 select; indices beyond NR yield zero.
  function automatic logic [127:0] rk(input logic [RK_W-1:0] bus, input logic [3:0] k);
    logic [127:0] sel;
    sel = '0;
    for (int j = 0; j <= NR; j++) begin
      if (k == 4'(j)) sel = bus[RK_W - 1 - 128 * j -: 128];
    end
    return sel;
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the last round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_key,
  input  logic         i_last,
  output logic [127:0] o_state
);

  logic [127:0] ark;
  logic [127:0] mixed;

  genvar gi;
  generate
    // Output byte (col c, row r) comes from input column (c - r) mod 4.
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * (((gi / 4) - ROW + 4) % 4) + ROW;
      assign ark[127 - 8 * gi -: 8] = inv_sbox(i_state[127 - 8 * SRC -: 8])
                                      ^ i_key[127 - 8 * gi -: 8];
    end

    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = ark[127 - 32 * gi -: 8];
      assign a1 = ark[119 - 32 * gi -: 8];
      assign a2 = ark[111 - 32 * gi -: 8];
      assign a3 = ark[103 - 32 * gi -: 8];
      assign mixed[127 - 32 * gi -: 32] = {
        gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3),
        gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3),
        gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3),
        gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3)
      };
    end
  endgenerate

  assign o_state = i_last ? ark : mixed;

endmodule

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, 11 cycles per block,
// reading round keys directly from the shared key-schedule bus.
module aes128_dec_iter #(
  parameter int NR = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [128*(NR+1)-1:0]  i_round_keys,
  input  logic                   i_keys_valid,
  input  logic                   i_start,
  input  logic [127:0]           i_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [127:0]           o_data
);
  import aes_pkg::*;

  dec_state_e   fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] data_q, data_d;
  logic         done_q, done_d;
  logic [127:0] rnd_key;
  logic [127:0] rnd_out;

  // rnd reaches 0 on entry to FINAL, so the same mux supplies rk0 there.
  assign rnd_key = rk(i_round_keys, rnd_q);

  aes_inv_round u_round (
    .i_state (state_q),
    .i_key   (rnd_key),
    .i_last  (fsm_q == ST_FINAL),
    .o_state (rnd_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (i_start && i_keys_valid) begin
          state_d = i_data ^ rk(i_round_keys, 4'(NR));
          rnd_d   = 4'(NR - 1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = rnd_out;
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) fsm_d = ST_FINAL;
      end
      ST_FINAL: begin
        data_d = rnd_out;
        done_d = 1'b1;
        fsm_d  = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q   <= ST_IDLE;
      rnd_q   <= 4'd0;
      state_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (fsm_q != ST_IDLE);
  assign o_done = done_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_aes128_dec_iter.sv
// Directed FIPS-197 vectors, start/reset corner cases and random round-trips
// through an independent forward-cipher model.
module tb_aes128_dec_iter;

  logic           i_clk = 1'b0;
  logic           i_rst_n = 1'b0;
  logic [1407:0]  i_round_keys = '0;
  logic           i_keys_valid = 1'b0;
  logic           i_start = 1'b0;
  logic [127:0]   i_data = '0;
  logic           o_busy;
  logic           o_done;
  logic [127:0]   o_data;

  int n_total = 0;
  int n_bad   = 0;

  always #5 i_clk = ~i_clk;

  aes128_dec_iter #(.NR(10)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_round_keys (i_round_keys),
    .i_keys_valid (i_keys_valid),
    .i_start      (i_start),
    .i_data       (i_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_data       (o_data)
  );

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] PT_2  = 128'hdeadbeef0123456789abcdeffedcba98;

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] x2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rcon;
    logic [1407:0] bus;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sb(t[23:16]) ^ rcon, sb(t[15:8]), sb(t[7:0]), sb(t[31:24])};
        rcon = x2(rcon);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int k = 0; k < 11; k++)
      bus[1407 - 128 * k -: 128] = {w[4 * k], w[4 * k + 1], w[4 * k + 2], w[4 * k + 3]};
    return bus;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8 * (4 * c + r) -: 8] = sb(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 32] = {x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3,
                               x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] bus);
    logic [127:0] s;
    s = pt ^ bus[1407 -: 128];
    for (int r = 1; r < 10; r++) s = mix(sub_shift(s)) ^ bus[1407 - 128 * r -: 128];
    return sub_shift(s) ^ bus[127:0];
  endfunction

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // Start on the next edge; return result, cycles to o_done and busy-cycle count.
  task automatic run_block(input logic [127:0] ct, output logic [127:0] pt,
                           output int lat, output int busy_cnt);
    @(negedge i_clk);
    i_data  = ct;
    i_start = 1'b1;
    lat = 0;
    busy_cnt = 0;
    do begin
      @(negedge i_clk);
      i_start = 1'b0;
      lat++;
      if (o_busy) busy_cnt++;
    end while (!o_done && lat < 30);
    pt = o_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1407:0] keys_c, keys_r;
    logic [127:0]  got, ct2, pt_r, ct_r;
    int            lat, bcnt, dcnt, dcyc;
    logic          seen_busy, seen_done, held_ok;

    keys_c = expand(KEY_C);
    ct2    = encrypt(PT_2, keys_c);

    // Reset state
    repeat (3) @(negedge i_clk);
    check_eq("rst_busy", 128'(o_busy), 128'd0);
    check_eq("rst_done", 128'(o_done), 128'd0);
    check_eq("rst_data", o_data, 128'd0);
    i_rst_n = 1'b1;
    $display("reset released");

    // Start with keys not valid is ignored
    i_round_keys = keys_c;
    @(negedge i_clk);
    i_data = CT_C;
    i_start = 1'b1;
    seen_busy = 1'b0;
    seen_done = 1'b0;
    repeat (15) begin
      @(negedge i_clk);
      i_start = 1'b0;
      seen_busy |= o_busy;
      seen_done |= o_done;
    end
    check_eq("nokey_busy", 128'(seen_busy), 128'd0);
    check_eq("nokey_done", 128'(seen_done), 128'd0);
    $display("start without keys: busy=%0b done=%0b", seen_busy, seen_done);

    // FIPS-197 C.1
    i_keys_valid = 1'b1;
    run_block(CT_C, got, lat, bcnt);
    $display("C.1 ct=%h pt=%h lat=%0d busy=%0d", CT_C, got, lat, bcnt);
    check_eq("c1_pt", got, PT_C);
    check_eq("c1_lat", 128'(lat), 128'd11);
    check_eq("c1_busy", 128'(bcnt), 128'd10);
    @(negedge i_clk);
    check_eq("c1_done_width", 128'(o_done), 128'd0);
    check_eq("c1_hold", o_data, PT_C);

    // Back-to-back: second start in the o_done cycle
    run_block(CT_C, got, lat, bcnt);
    check_eq("b2b_first", got, PT_C);
    i_data = ct2;
    i_start = 1'b1;
    lat = 0;
    held_ok = 1'b1;
    do begin
      @(negedge i_clk);
      i_start = 1'b0;
      lat++;
      if (!o_done && o_data !== PT_C) held_ok = 1'b0;
    end while (!o_done && lat < 30);
    $display("b2b ct=%h pt=%h lat=%0d held=%0b", ct2, o_data, lat, held_ok);
    check_eq("b2b_lat", 128'(lat), 128'd11);
    check_eq("b2b_hold", 128'(held_ok), 128'd1);
    check_eq("b2b_pt", o_data, PT_2);

    // Starts in cycles 3 and 7 of a block are ignored
    @(negedge i_clk);
    i_data = CT_C;
    i_start = 1'b1;
    dcnt = 0;
    dcyc = 0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge i_clk);
      if (o_done) begin
        dcnt++;
        if (dcyc == 0) dcyc = cyc;
      end
      i_data  = ct2;
      i_start = (cyc == 3 || cyc == 7);
    end
    i_start = 1'b0;
    $display("busy starts: dones=%0d first=%0d pt=%h", dcnt, dcyc, o_data);
    check_eq("ign_done_cnt", 128'(dcnt), 128'd1);
    check_eq("ign_done_cyc", 128'(dcyc), 128'd11);
    check_eq("ign_pt", o_data, PT_C);

    // Reset in cycle 5 of a block
    @(negedge i_clk);
    i_data = ct2;
    i_start = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      i_start = 1'b0;
    end
    check_eq("mid_busy_pre", 128'(o_busy), 128'd1);
    i_rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", 128'(o_busy), 128'd0);
    check_eq("mid_rst_done", 128'(o_done), 128'd0);
    check_eq("mid_rst_data", o_data, 128'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge i_clk);
      seen_done |= o_done;
    end
    check_eq("mid_rst_nodone", 128'(seen_done), 128'd0);
    run_block(CT_C, got, lat, bcnt);
    $display("after reset C.1 pt=%h lat=%0d", got, lat);
    check_eq("post_rst_pt", got, PT_C);
    check_eq("post_rst_lat", 128'(lat), 128'd11);

    // FIPS-197 Appendix B
    i_round_keys = expand(KEY_B);
    run_block(CT_B, got, lat, bcnt);
    $display("App.B ct=%h pt=%h lat=%0d", CT_B, got, lat);
    check_eq("appb_pt", got, PT_B);

    // Random round-trips sharing one key schedule
    keys_r = expand({$urandom, $urandom, $urandom, $urandom});
    i_round_keys = keys_r;
    for (int n = 0; n < 1000; n++) begin
      pt_r = {$urandom, $urandom, $urandom, $urandom};
      ct_r = encrypt(pt_r, keys_r);
      run_block(ct_r, got, lat, bcnt);
      $display("rt %0d ct=%h pt=%h got=%h", n, ct_r, pt_r, got);
      check_eq("rt_pt", got, pt_r);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/aes128_dec_iter.md
# aes128_dec_iter

Iterative AES-128 inverse cipher (FIPS-197 §5.3) that recovers plaintext from ciphertext produced by the pipelined AES-128 encryptor. It executes one inverse round per clock and consumes the same 1408-bit round-key bus the key-schedule block already produces, so one key expansion serves both directions. It sits beside the encryptor in the FrodoKEM datapath. It trades throughput (one block per 11 cycles) for area: a single inverse-round datapath instead of ten.

## Interface

- `NR`, default 10: number of rounds. Fixed for AES-128. Other values are unsupported.
- `i_clk`, input, 1 bit: clock. All state updates on the rising edge.
- `i_rst_n`, input, 1 bit: asynchronous, active-low reset.
- `i_round_keys`, input, 1408 bits: expanded key bus. Round key k occupies `[1407-128*k -: 128]`, so rk0 is at the MSBs and rk10 at bits [127:0].
- `i_keys_valid`, input, 1 bit: key-schedule done flag. The key bus must stay stable while it is high.
- `i_start`, input, 1 bit: start request. Sampled only in IDLE.
- `i_data`, input, 128 bits: ciphertext. Sampled only on an accepted start.
- `o_busy`, output, 1 bit: high while a block is in flight.
- `o_done`, output, 1 bit: one-cycle pulse when `o_data` is updated.
- `o_data`, output, 128 bits: plaintext. Registered and held until the next completion.

## Operation

- Byte order: byte 0 is `[127:120]`. Column-major state, as in FIPS-197.
- FSM has three states:
  - **IDLE**: `o_busy`=0. If `i_start && i_keys_valid`, then `state <= i_data ^ rk10`, `rnd <= 9`, go to ROUND. Otherwise stay in IDLE.
  - **ROUND**: `state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[rnd]))`, then `rnd <= rnd-1`. When `rnd == 1`, go to FINAL.
  - **FINAL**: `o_data <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0)`, `o_done <= 1`, go to IDLE.
- `rnd` is a 4-bit down-counter. It never wraps: it is reloaded only on start.
- Round-key select is a 16:1 mux on `rnd`, driven from the package slice function.
- Starts are ignored in these cases (no queuing, no error flag):
  - `i_start` while busy.
  - `i_start` with `i_keys_valid` low.
- Key stability: the keys are not latched. The key schedule must not restart while `o_busy`=1. If `i_keys_valid` drops mid-block, the result is undefined, but the FSM still completes and pulses `o_done`.
- Reset, asserted at any time including mid-block:
  - FSM goes to IDLE, `rnd`=0, `state`=0.
  - `o_busy`=0, `o_done`=0, `o_data`=0.
  - The in-flight block is discarded with no `o_done`.

## Timing

- Latency: `i_start` accepted in cycle 0 gives `o_done`=1 and valid `o_data` in cycle 11.
- `o_busy` is high in cycles 1–10 (registered, derived from the FSM state).
- `o_done` is high for exactly one cycle, and the FSM is back in IDLE in that same cycle. A start in the `o_done` cycle is accepted, so back-to-back blocks complete every 11 cycles.
- Critical path (one cycle):
  - ROUND: inverse S-box, then rk XOR, then InvMixColumns.
  - FINAL: inverse S-box, then rk XOR.

## Structure

- Shared package `aes_pkg`, also importable by the encryptor side:
  - `NR` and `NK` constants.
  - The 256-entry inverse S-box function.
  - The `xtime` and GF(2^8) multiply-by-{09,0b,0d,0e} functions.
  - The round-key slice function `rk(bus, k)`.
  - The FSM state enum (IDLE/ROUND/FINAL).
- One combinational sub-module, `aes_inv_round`:
  - Inputs: `state`, `key`, `last`.
  - Output: the next state.
  - When `last` is high, InvMixColumns is skipped.
- The top level holds the FSM, `rnd`, the state register, the key mux and the output register.

## Test plan

- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a. Expect `o_data` 00112233445566778899aabbccddeeff with `o_done` exactly 11 cycles after start.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32. Expect pt 3243f6a8885a308d313198a2e0370734.
- Round-trip: 1000 random plaintexts through the encryptor and then this block, sharing one key schedule. Every output must equal its original plaintext.
- Start handling:
  - Pulse `i_start` in cycles 3 and 7 of a block: exactly one `o_done`, and the result is for the first block.
  - Start with `i_keys_valid`=0: no `o_busy` and no `o_done`.
- Reset and back-to-back:
  - Drop `i_rst_n` in cycle 5: all outputs go to 0 immediately. The next start with C.1 vectors gives the correct pt in 11 cycles.
  - Start asserted in the `o_done` cycle: the second result appears 11 cycles later, and the first `o_data` is held until then.
